// File: rtl/data_mem_dumper.sv
// Debug read-out engine: walks an inclusive word range of the data memory and serialises each word little-endian onto a byte stream.
// Optional macro DUMP_HEADER_EN prefixes the stream with 0xA5 and the low byte of the word count.
module data_mem_dumper #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_halt,
    input  logic [NB_ADDR-1:0] i_first_addr,
    input  logic [NB_ADDR-1:0] i_last_addr,
    output logic [NB_ADDR-1:0] o_mem_addr,
    input  logic [NB_DATA-1:0] i_mem_data,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int NB_BYTES = NB_DATA / 8;
    localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SEND   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t             state_r, state_s;
    logic [NB_ADDR-1:0] addr_r, addr_s;
    logic [NB_ADDR-1:0] last_r, last_s;
    logic [NB_DATA-1:0] word_r, word_s;
    logic [NB_BCNT-1:0] bcnt_r, bcnt_s;
    logic               hdr_r, hdr_s;
    logic [7:0]         tx_data_r, tx_data_s;
    logic               tx_valid_r, tx_valid_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;

    function automatic logic [7:0] byte_sel(input logic [NB_DATA-1:0] w, input logic [NB_BCNT-1:0] idx);
        byte_sel = w[int'(idx) * 8 +: 8];
    endfunction

`ifdef DUMP_HEADER_EN
    // Word count of an inclusive modular range; 0 stands for the full address space.
    function automatic logic [7:0] count_byte(input logic [NB_ADDR-1:0] last, input logic [NB_ADDR-1:0] first);
        logic [NB_ADDR-1:0] cnt;
        logic [NB_ADDR+7:0] wide;
        cnt        = last - first + NB_ADDR'(1);
        wide       = {8'h00, cnt};
        count_byte = wide[7:0];
    endfunction
`endif

    // Next-state and registered-output values, all outputs derived from the next state.
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        last_s     = last_r;
        word_s     = word_r;
        bcnt_s     = bcnt_r;
        hdr_s      = hdr_r;
        tx_data_s  = tx_data_r;
        tx_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_start && i_halt) begin
                    addr_s = i_first_addr;
                    last_s = i_last_addr;
`ifdef DUMP_HEADER_EN
                    state_s    = ST_HEADER;
                    hdr_s      = 1'b0;
                    tx_data_s  = 8'hA5;
                    tx_valid_s = 1'b1;
`else
                    state_s = ST_LOAD;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
`ifdef DUMP_HEADER_EN
            ST_HEADER: begin
                tx_valid_s = 1'b1;
                if (i_tx_ready) begin
                    if (hdr_r) begin
                        state_s    = ST_LOAD;
                        tx_valid_s = 1'b0;
                    end else begin
                        hdr_s     = 1'b1;
                        tx_data_s = count_byte(last_r, addr_r);
                    end
                end else begin
                    hdr_s = hdr_r;
                end
            end
`endif
            ST_LOAD: begin
                word_s     = i_mem_data;
                bcnt_s     = '0;
                tx_data_s  = i_mem_data[7:0];
                tx_valid_s = 1'b1;
                state_s    = ST_SEND;
            end
            ST_SEND: begin
                tx_valid_s = 1'b1;
                if (i_tx_ready) begin
                    if (bcnt_r == LAST_BYTE) begin
                        state_s    = ST_NEXT;
                        tx_valid_s = 1'b0;
                    end else begin
                        bcnt_s    = bcnt_r + NB_BCNT'(1);
                        tx_data_s = byte_sel(word_r, bcnt_s);
                    end
                end else begin
                    bcnt_s = bcnt_r;
                end
            end
            ST_NEXT: begin
                if (!i_halt) begin
                    state_s = ST_IDLE;
                end else if (addr_r == last_r) begin
                    state_s = ST_DONE;
                end else begin
                    addr_s  = addr_r + NB_ADDR'(1);
                    state_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // State register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_r     <= '0;
            last_r     <= '0;
            word_r     <= '0;
            bcnt_r     <= '0;
            hdr_r      <= 1'b0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            addr_r     <= addr_s;
            last_r     <= last_s;
            word_r     <= word_s;
            bcnt_r     <= bcnt_s;
            hdr_r      <= hdr_s;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign o_mem_addr = addr_r;
    assign o_tx_data  = tx_data_r;
    assign o_tx_valid = tx_valid_r;
    assign o_busy     = busy_r;
    assign o_done     = done_r;

endmodule
